// File: rtl/vec3_fixed_normalizer.sv
// vec3_fixed_normalizer: pipelined signed fixed-point 3-vector normalizer.
// Stages: square (1), sum (1), non-restoring sqrt (WIDTH+1), restoring
// divide (Q_BITS+1), output register (1). Latency WIDTH+Q_BITS+5, one
// vector per cycle, tag carried alongside the data.
// Optional build macro NORM_MAG_OUT_EN adds mag_out (the magnitude M).
module vec3_fixed_normalizer #(
  parameter int WIDTH    = 16,
  parameter int Q_BITS   = 8,
  parameter int TAG_SIZE = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [WIDTH-1:0]    x_in,
  input  logic [WIDTH-1:0]    y_in,
  input  logic [WIDTH-1:0]    z_in,
  input  logic [TAG_SIZE-1:0] tag_in,
  output logic [WIDTH-1:0]    x_out,
  output logic [WIDTH-1:0]    y_out,
  output logic [WIDTH-1:0]    z_out,
  output logic [TAG_SIZE-1:0] tag_out,
  output logic                valid_out
`ifdef NORM_MAG_OUT_EN
  ,
  output logic [WIDTH:0]      mag_out
`endif
);

  localparam int SW = 2*WIDTH+2;        // sum of squares width
  localparam int RN = WIDTH+1;          // root bits = sqrt stages
  localparam int RW = RN+3;             // signed partial remainder width
  localparam int QN = Q_BITS+1;         // quotient bits = divide stages
  localparam int DW = WIDTH+Q_BITS+1;   // dividend / shifted divisor width

  // ---------------- stage 1: absolute values and full-width squares
  logic [2:0][WIDTH-1:0]   in_vec;
  logic [2:0][2*WIDTH-1:0] m_ext;
  logic [2:0][2*WIDTH-1:0] m_sq_d;
  logic [2:0][WIDTH-1:0]   m_abs_d;
  logic [2:0]              m_sgn_d;
  logic                    m_vld_q;
  logic [TAG_SIZE-1:0]     m_tag_q;
  logic [2:0][2*WIDTH-1:0] m_sq_q;
  logic [2:0][WIDTH-1:0]   m_abs_q;
  logic [2:0]              m_sgn_q;

  assign in_vec = {z_in, y_in, x_in};

  // Sign-extend to double width so the most-negative input squares exactly.
  always_comb begin
    for (int c = 0; c < 3; c++) begin
      m_ext[c]   = {{WIDTH{in_vec[c][WIDTH-1]}}, in_vec[c]};
      m_sq_d[c]  = m_ext[c] * m_ext[c];
      m_sgn_d[c] = in_vec[c][WIDTH-1];
      m_abs_d[c] = in_vec[c][WIDTH-1] ? (~in_vec[c]) + 1'b1 : in_vec[c];
    end
  end

  // Register squares, magnitudes, signs and tag.
  always_ff @(posedge clk) begin
    if (reset) m_vld_q <= 1'b0;
    else       m_vld_q <= start;
    m_tag_q <= tag_in;
    m_sq_q  <= m_sq_d;
    m_abs_q <= m_abs_d;
    m_sgn_q <= m_sgn_d;
  end

  // ---------------- stage 2 + sqrt pipeline (index 0 = sum register)
  logic                    sq_vld_q  [0:RN];
  logic [TAG_SIZE-1:0]     sq_tag_q  [0:RN];
  logic [RW-1:0]           sq_rem_q  [0:RN];
  logic [RN-1:0]           sq_root_q [0:RN];
  logic [SW-1:0]           sq_rad_q  [0:RN];
  logic [2:0][WIDTH-1:0]   sq_abs_q  [0:RN];
  logic [2:0]              sq_sgn_q  [0:RN];
  logic [RW-1:0]           sq_rem_d  [0:RN-1];
  logic [RN-1:0]           sq_root_d [0:RN-1];
  logic [SW-1:0]           sq_rad_d  [0:RN-1];

  // Non-restoring step: bring down two radicand bits, then subtract
  // (4Q+1) on a non-negative remainder or add (4Q+3) on a negative one.
  always_comb begin
    for (int k = 0; k < RN; k++) begin
      if (sq_rem_q[k][RW-1])
        sq_rem_d[k] = ((sq_rem_q[k] << 2) | {{(RW-2){1'b0}}, sq_rad_q[k][SW-1:SW-2]})
                      + {1'b0, sq_root_q[k], 2'b11};
      else
        sq_rem_d[k] = ((sq_rem_q[k] << 2) | {{(RW-2){1'b0}}, sq_rad_q[k][SW-1:SW-2]})
                      - {1'b0, sq_root_q[k], 2'b01};
      sq_rad_d[k] = {sq_rad_q[k][SW-3:0], 2'b00};
    end
  end

  // New root bit is 1 when the updated remainder is non-negative.
  always_comb begin
    for (int k = 0; k < RN; k++)
      sq_root_d[k] = {sq_root_q[k][RN-2:0], ~sq_rem_d[k][RW-1]};
  end

  // Sum of squares into slot 0, then one root bit per registered slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k <= RN; k++) sq_vld_q[k] <= 1'b0;
    end else begin
      sq_vld_q[0] <= m_vld_q;
      for (int k = 0; k < RN; k++) sq_vld_q[k+1] <= sq_vld_q[k];
    end
    sq_tag_q[0]  <= m_tag_q;
    sq_rem_q[0]  <= '0;
    sq_root_q[0] <= '0;
    sq_rad_q[0]  <= {2'b00, m_sq_q[0]} + {2'b00, m_sq_q[1]} + {2'b00, m_sq_q[2]};
    sq_abs_q[0]  <= m_abs_q;
    sq_sgn_q[0]  <= m_sgn_q;
    for (int k = 0; k < RN; k++) begin
      sq_tag_q[k+1]  <= sq_tag_q[k];
      sq_rem_q[k+1]  <= sq_rem_d[k];
      sq_root_q[k+1] <= sq_root_d[k];
      sq_rad_q[k+1]  <= sq_rad_d[k];
      sq_abs_q[k+1]  <= sq_abs_q[k];
      sq_sgn_q[k+1]  <= sq_sgn_q[k];
    end
  end

  // ---------------- divide pipeline: registers [1:QN], stage inputs [0:QN-1]
  logic                  dv_vld_q [1:QN];
  logic [TAG_SIZE-1:0]   dv_tag_q [1:QN];
  logic [2:0][DW-1:0]    dv_rem_q [1:QN];
  logic [2:0][QN-1:0]    dv_quo_q [1:QN];
  logic [RN-1:0]         dv_mag_q [1:QN];
  logic [2:0]            dv_sgn_q [1:QN];
  logic                  di_vld   [0:QN-1];
  logic [TAG_SIZE-1:0]   di_tag   [0:QN-1];
  logic [2:0][DW-1:0]    di_rem   [0:QN-1];
  logic [2:0][QN-1:0]    di_quo   [0:QN-1];
  logic [RN-1:0]         di_mag   [0:QN-1];
  logic [2:0]            di_sgn   [0:QN-1];
  logic [DW-1:0]         dv_div   [0:QN-1];
  logic [2:0][DW-1:0]    dv_rem_d [0:QN-1];
  logic [2:0][QN-1:0]    dv_quo_d [0:QN-1];

  // First divide stage reads the sqrt result directly; later ones read registers.
  always_comb begin
    di_vld[0] = sq_vld_q[RN];
    di_tag[0] = sq_tag_q[RN];
    di_mag[0] = sq_root_q[RN];
    di_sgn[0] = sq_sgn_q[RN];
    di_quo[0] = '0;
    for (int c = 0; c < 3; c++)
      di_rem[0][c] = {1'b0, sq_abs_q[RN][c], {Q_BITS{1'b0}}};
    for (int k = 1; k < QN; k++) begin
      di_vld[k] = dv_vld_q[k];
      di_tag[k] = dv_tag_q[k];
      di_mag[k] = dv_mag_q[k];
      di_sgn[k] = dv_sgn_q[k];
      di_quo[k] = dv_quo_q[k];
      di_rem[k] = dv_rem_q[k];
    end
  end

  // Divisor M aligned to the quotient bit resolved in each stage (MSB first).
  always_comb begin
    for (int k = 0; k < QN; k++)
      dv_div[k] = {{(DW-RN){1'b0}}, di_mag[k]} << (QN-1-k);
  end

  // Restoring step: subtract when it fits; |c| <= M keeps the quotient in QN bits.
  always_comb begin
    for (int k = 0; k < QN; k++) begin
      for (int c = 0; c < 3; c++) begin
        dv_rem_d[k][c] = (di_rem[k][c] >= dv_div[k]) ? di_rem[k][c] - dv_div[k] : di_rem[k][c];
        dv_quo_d[k][c] = {di_quo[k][c][QN-2:0], (di_rem[k][c] >= dv_div[k])};
      end
    end
  end

  // Advance the three parallel dividers by one quotient bit per stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 1; k <= QN; k++) dv_vld_q[k] <= 1'b0;
    end else begin
      for (int k = 0; k < QN; k++) dv_vld_q[k+1] <= di_vld[k];
    end
    for (int k = 0; k < QN; k++) begin
      dv_tag_q[k+1] <= di_tag[k];
      dv_mag_q[k+1] <= di_mag[k];
      dv_sgn_q[k+1] <= di_sgn[k];
      dv_rem_q[k+1] <= dv_rem_d[k];
      dv_quo_q[k+1] <= dv_quo_d[k];
    end
  end

  // ---------------- output stage
  logic [2:0][WIDTH-1:0] q_ext;
  logic [2:0][WIDTH-1:0] res_d;

  // Reapply signs; a zero magnitude forces a zero result (quotient is garbage).
  always_comb begin
    for (int c = 0; c < 3; c++) begin
      q_ext[c] = {{(WIDTH-QN){1'b0}}, dv_quo_q[QN][c]};
      if (dv_mag_q[QN] == '0)     res_d[c] = '0;
      else if (dv_sgn_q[QN][c])   res_d[c] = (~q_ext[c]) + 1'b1;
      else                        res_d[c] = q_ext[c];
    end
  end

  // Output register: pulses valid_out, holds data between results.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_out <= 1'b0;
      x_out     <= '0;
      y_out     <= '0;
      z_out     <= '0;
      tag_out   <= '0;
`ifdef NORM_MAG_OUT_EN
      mag_out   <= '0;
`endif
    end else begin
      valid_out <= dv_vld_q[QN];
      if (dv_vld_q[QN]) begin
        x_out   <= res_d[0];
        y_out   <= res_d[1];
        z_out   <= res_d[2];
        tag_out <= dv_tag_q[QN];
`ifdef NORM_MAG_OUT_EN
        mag_out <= dv_mag_q[QN];
`endif
      end
    end
  end

endmodule

// File: tb/tb_vec3_fixed_normalizer.sv
// Scoreboard bench for vec3_fixed_normalizer: stimulus pushes expected
// results, a negedge monitor pops and compares whenever valid_out is high.
module tb_vec3_fixed_normalizer;
  localparam int W = 16;
  localparam int Q = 8;
  localparam int T = 8;
  localparam int L = W + Q + 5;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] x_in, y_in, z_in;
  logic [T-1:0] tag_in;
  logic [W-1:0] x_out, y_out, z_out;
  logic [T-1:0] tag_out;
  logic         valid_out;
`ifdef NORM_MAG_OUT_EN
  logic [W:0]   mag_out;
`endif

  vec3_fixed_normalizer #(.WIDTH(W), .Q_BITS(Q), .TAG_SIZE(T)) dut (
    .clk(clk), .reset(reset), .start(start),
    .x_in(x_in), .y_in(y_in), .z_in(z_in), .tag_in(tag_in),
    .x_out(x_out), .y_out(y_out), .z_out(z_out), .tag_out(tag_out),
    .valid_out(valid_out)
`ifdef NORM_MAG_OUT_EN
    , .mag_out(mag_out)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] x, y, z;
    logic [T-1:0] tag;
    logic [W:0]   mag;
    int           due;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int checks = 0;
  int passes = 0;

  task automatic check(string name, longint act, longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic longint isqrt(longint s);
    longint m = longint'($sqrt(real'(s)));
    while (m * m > s) m--;
    while ((m + 1) * (m + 1) <= s) m++;
    return m;
  endfunction

  function automatic logic [W-1:0] nrm(logic [W-1:0] c, longint m);
    longint v = longint'($signed(c));
    longint a = (v < 0) ? -v : v;
    longint q;
    if (m == 0) return '0;
    q = (a <<< Q) / m;
    return W'((v < 0) ? -q : q);
  endfunction

  function automatic longint sabs(logic [W-1:0] c);
    longint v = longint'($signed(c));
    return (v < 0) ? -v : v;
  endfunction

  task automatic send(logic [W-1:0] x, logic [W-1:0] y, logic [W-1:0] z, logic [T-1:0] tag,
                      logic [W-1:0] ex, logic [W-1:0] ey, logic [W-1:0] ez, logic [W:0] em,
                      bit push);
    exp_t n;
    @(posedge clk); #1;
    start = 1'b1; x_in = x; y_in = y; z_in = z; tag_in = tag;
    n.x = ex; n.y = ey; n.z = ez; n.tag = tag; n.mag = em; n.due = cyc + L;
    if (push) sb.push_back(n);
    $display("issue tag=%0d in=(%0d,%0d,%0d) push=%0d cycle=%0d",
             tag, $signed(x), $signed(y), $signed(z), push, cyc);
  endtask

  task automatic send_model(logic [W-1:0] x, logic [W-1:0] y, logic [W-1:0] z,
                            logic [T-1:0] tag, bit push);
    longint s = sabs(x) * sabs(x) + sabs(y) * sabs(y) + sabs(z) * sabs(z);
    longint m = isqrt(s);
    send(x, y, z, tag, nrm(x, m), nrm(y, m), nrm(z, m), (W+1)'(m), push);
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  task automatic drain(string name);
    int b = 0;
    while (sb.size() != 0 && b < 4 * L) begin
      @(posedge clk);
      b++;
    end
    idle(3);
    check(name, sb.size(), 0);
  endtask

  // Monitor: compare every output pulse against the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (valid_out) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          $display("result tag=%0d out=(%0d,%0d,%0d) cycle=%0d", tag_out,
                   $signed(x_out), $signed(y_out), $signed(z_out), cyc);
          check("latency", cyc, e.due);
          check("x_out", longint'($signed(x_out)), longint'($signed(e.x)));
          check("y_out", longint'($signed(y_out)), longint'($signed(e.y)));
          check("z_out", longint'($signed(z_out)), longint'($signed(e.z)));
          check("tag_out", tag_out, e.tag);
          check("no_x", $isunknown({x_out, y_out, z_out, tag_out}), 0);
          check("range", (sabs(x_out) <= 256 && sabs(y_out) <= 256 && sabs(z_out) <= 256), 1);
`ifdef NORM_MAG_OUT_EN
          check("mag_out", mag_out, e.mag);
`endif
        end
      end else if (sb.size() != 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        check("missing_valid", cyc, e.due + 1);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] rx, ry, rz;
    reset = 1'b1; start = 1'b0;
    x_in = '0; y_in = '0; z_in = '0; tag_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", valid_out, 0);
    check("rst_x", x_out, 0);
    check("rst_y", y_out, 0);
    check("rst_z", z_out, 0);
    check("rst_tag", tag_out, 0);
`ifdef NORM_MAG_OUT_EN
    check("rst_mag", mag_out, 0);
`endif
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed vectors with hand-computed results.
    send(16'd768, 16'd1024, 16'd0, 8'd5, 16'd153, 16'd204, 16'd0, 17'd1280, 1);
    idle(2);
    send(-16'sd256, 16'd0, 16'd0, 8'd6, -16'sd256, 16'd0, 16'd0, 17'd256, 1);
    send(16'd0, 16'd0, 16'd640, 8'd7, 16'd0, 16'd0, 16'd256, 17'd640, 1);
    send(16'd0, 16'd0, 16'd0, 8'd8, 16'd0, 16'd0, 16'd0, 17'd0, 1);
    send(16'd1, 16'd1, 16'd1, 8'd9, 16'd256, 16'd256, 16'd256, 17'd1, 1);
    send(16'h8000, 16'd0, 16'd0, 8'd10, -16'sd256, 16'd0, 16'd0, 17'd32768, 1);
    send(16'd0, -16'sd1, 16'd0, 8'd11, 16'd0, -16'sd256, 16'd0, 17'd1, 1);
    idle(1);
    drain("drain_directed");

    // 100 back-to-back vectors against the reference model.
    for (int i = 0; i < 100; i++) begin
      if (i % 10 == 0) begin
        rx = W'($urandom_range(0, 15)) - 16'd8;
        ry = W'($urandom_range(0, 15)) - 16'd8;
        rz = W'($urandom_range(0, 15)) - 16'd8;
      end else begin
        rx = W'($urandom); ry = W'($urandom); rz = W'($urandom);
      end
      send_model(rx, ry, rz, T'(i), 1);
    end
    idle(1);
    drain("drain_random");

    // Reset with items in flight: none of them may appear.
    for (int i = 0; i < 10; i++)
      send_model(W'($urandom), W'($urandom), W'($urandom), T'(200 + i), 0);
    @(posedge clk); #1;
    start = 1'b0; reset = 1'b1;
    @(negedge clk);
    check("inrst_valid", valid_out, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("inrst_valid2", valid_out, 0);
    check("inrst_x", x_out, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    send(16'd768, 16'd1024, 16'd0, 8'd42, 16'd153, 16'd204, 16'd0, 17'd1280, 1);
    idle(L + 10);
    drain("drain_after_reset");

    // Gapped start pattern 1,0,0,1,1.
    send_model(16'd300, -16'sd400, 16'd1200, 8'd50, 1);
    idle(2);
    send_model(-16'sd5000, 16'd77, 16'd0, 8'd51, 1);
    send_model(16'd12, 16'd34, -16'sd56, 8'd52, 1);
    idle(1);
    drain("drain_gapped");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
